// File: rtl/fpmul_seq_ctrl.sv
// Sequential IEEE-754 single-precision multiplier controller.
// Shift-add mantissa multiply over 24 cycles, truncating normalise, special bypass.
module fpmul_seq_ctrl #(
  parameter int SPECIAL_FAST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_p,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    NORM,
    DONE
  } state_t;

  state_t             state;
  logic               sign;
  logic signed [9:0]  exp_sum;
  logic [23:0]        mant_a;
  logic [23:0]        mant_b;
  logic [47:0]        acc;
  logic [4:0]         cnt;
  logic               spec;
  logic [31:0]        spec_p;

  logic [7:0]         a_exp;
  logic [7:0]         b_exp;
  logic               a_zero;
  logic               b_zero;
  logic               a_inf;
  logic               b_inf;
  logic               any_nan;
  logic               in_spec;
  logic               in_sign;
  logic [31:0]        spec_res;
  logic signed [9:0]  exp_n;
  logic [22:0]        man_n;

  assign in_ready = (state == IDLE);
  assign busy     = !in_ready;

  assign a_exp   = in_a[30:23];
  assign b_exp   = in_b[30:23];
  assign a_zero  = (a_exp == 8'h00);
  assign b_zero  = (b_exp == 8'h00);
  assign a_inf   = (a_exp == 8'hFF) && (in_a[22:0] == 23'h0);
  assign b_inf   = (b_exp == 8'hFF) && (in_b[22:0] == 23'h0);
  assign any_nan = ((a_exp == 8'hFF) && (in_a[22:0] != 23'h0))
                || ((b_exp == 8'hFF) && (in_b[22:0] != 23'h0));
  assign in_spec = a_zero || b_zero
                || (a_exp == 8'hFF) || (b_exp == 8'hFF);
  assign in_sign = in_a[31] ^ in_b[31];

  always_comb begin
    spec_res = {in_sign, 31'h0};
    if (any_nan || (a_inf && b_zero) || (b_inf && a_zero))
      spec_res = 32'h7FC00000;
    else if (a_inf || b_inf)
      spec_res = {in_sign, 8'hFF, 23'h0};
  end

  // Product of two 1.x mantissas lies in [1,4): bit 47 picks the shift.
  always_comb begin
    exp_n = exp_sum;
    man_n = acc[45:23];
    if (acc[47]) begin
      exp_n = exp_sum + 10'sd1;
      man_n = acc[46:24];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_p     <= 32'h0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
      cnt       <= 5'd0;
      acc       <= 48'h0;
      sign      <= 1'b0;
      exp_sum   <= 10'sd0;
      mant_a    <= 24'h0;
      mant_b    <= 24'h0;
      spec      <= 1'b0;
      spec_p    <= 32'h0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign    <= in_sign;
            exp_sum <= $signed({2'b00, a_exp} + {2'b00, b_exp} - 10'd127);
            mant_a  <= {1'b1, in_a[22:0]};
            mant_b  <= {1'b1, in_b[22:0]};
            acc     <= 48'h0;
            cnt     <= 5'd0;
            spec    <= in_spec;
            spec_p  <= spec_res;
            if ((SPECIAL_FAST != 0) && in_spec) begin
              out_p     <= spec_res;
              out_ovf   <= 1'b0;
              out_unf   <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= MUL;
            end
          end
        end
        MUL: begin
          if (mant_b[cnt])
            acc <= acc + ({24'h0, mant_a} << cnt);
          cnt <= cnt + 5'd1;
          if (cnt == 5'd23)
            state <= NORM;
        end
        NORM: begin
          out_valid <= 1'b1;
          state     <= DONE;
          out_ovf   <= 1'b0;
          out_unf   <= 1'b0;
          if (spec) begin
            out_p <= spec_p;
          end else if (exp_n >= 10'sd255) begin
            out_p   <= {sign, 8'hFF, 23'h0};
            out_ovf <= 1'b1;
          end else if (exp_n <= 10'sd0) begin
            out_p   <= {sign, 31'h0};
            out_unf <= 1'b1;
          end else begin
            out_p <= {sign, exp_n[7:0], man_n};
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_seq_ctrl.sv
// Directed bench for fpmul_seq_ctrl (SPECIAL_FAST = 1).
// Each task drives one scenario and compares against hand-computed values.
module tb_fpmul_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic        out_ovf;
  logic        out_unf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fpmul_seq_ctrl #(.SPECIAL_FAST(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands at a falling edge, accept on the next rising edge,
  // then scramble the inputs to prove they are not re-sampled.
  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 32'hDEADBEEF;
    in_b     = 32'h12345678;
  endtask

  // lat = rising edges after the accept edge until out_valid is seen.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_normal(input string name, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_p,
                            input logic e_ovf, input logic e_unf);
    int lat;
    accept(a, b);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: busy=%b in_ready=%b required 1/0", name, busy, in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 25) begin
      errors++;
      $display("FAIL %s_latency: got %0d required 25", name, lat);
    end
    checks++;
    if (out_p !== exp_p || out_ovf !== e_ovf || out_unf !== e_unf) begin
      errors++;
      $display("FAIL %s_result: p=%h ovf=%b unf=%b required p=%h ovf=%b unf=%b",
               name, out_p, out_ovf, out_unf, exp_p, e_ovf, e_unf);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_p !== exp_p) begin
      errors++;
      $display("FAIL %s_release: valid=%b in_ready=%b p=%h required 0/1/%h",
               name, out_valid, in_ready, out_p, exp_p);
    end
  endtask

  task automatic run_special(input string name, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_p);
    int lat;
    accept(a, b);
    wait_valid(lat);
    checks++;
    if (lat > 1) begin
      errors++;
      $display("FAIL %s_latency: got %0d required <=1", name, lat);
    end
    checks++;
    if (out_p !== exp_p || out_ovf !== 1'b0 || out_unf !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: p=%h ovf=%b unf=%b required p=%h ovf=0 unf=0",
               name, out_p, out_ovf, out_unf, exp_p);
    end
    release_out();
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = 32'h0;
    in_b      = 32'h0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_p !== 32'h0 || out_ovf !== 1'b0 ||
        out_unf !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: v=%b p=%h ovf=%b unf=%b rdy=%b busy=%b required 0/0/0/0/1/0",
               out_valid, out_p, out_ovf, out_unf, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_normal("basic", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
  endtask

  task automatic test_norm();
    run_normal("norm", 32'h3FC00000, 32'h3FC00000, 32'h40100000, 1'b0, 1'b0);
    run_normal("neg", 32'hBFC00000, 32'h40000000, 32'hC0400000, 1'b0, 1'b0);
  endtask

  task automatic test_range();
    run_normal("ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0);
    run_normal("unf", 32'h00800000, 32'h00800000, 32'h00000000, 1'b0, 1'b1);
  endtask

  task automatic test_specials();
    run_special("zero", 32'h80000000, 32'h40490FDB, 32'h80000000);
    run_special("inf_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000);
    run_special("inf", 32'hFF800000, 32'h40000000, 32'hFF800000);
    run_special("nan", 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] held;
    accept(32'h3FC00000, 32'h40000000);
    wait_valid(lat);
    held = out_p;
    checks++;
    if (held !== 32'h40400000) begin
      errors++;
      $display("FAIL bp_first: p=%h required 40400000", held);
    end
    @(negedge clk);
    in_a     = 32'h3FC00000;
    in_b     = 32'h3FC00000;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_p !== 32'h40400000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: p=%h v=%b rdy=%b required 40400000/1/0",
                 i, out_p, out_valid, in_ready);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rdy=%b v=%b busy=%b required 1/0/0",
               in_ready, out_valid, busy);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a     = 32'h0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: busy=%b required 1", busy);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 25 || out_p !== 32'h40100000) begin
      errors++;
      $display("FAIL bp_second: lat=%0d p=%h required 25/40100000", lat, out_p);
    end
    release_out();
  endtask

  task automatic test_reset_midop();
    accept(32'h3FC00000, 32'h40000000);
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_p !== 32'h0 || out_ovf !== 1'b0 ||
        out_unf !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: v=%b p=%h ovf=%b unf=%b rdy=%b busy=%b required 0/0/0/0/1/0",
               out_valid, out_p, out_ovf, out_unf, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midop_no_result: v=%b rdy=%b required 0/1", out_valid, in_ready);
    end
    run_normal("after_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_norm();
    test_range();
    test_specials();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpmul_seq_ctrl.md
FPMUL_SEQ_CTRL -- requirements
Module: fpmul_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low, and the ports are named clk and rst_n.
REQ-002 The block SHALL have parameter SPECIAL_FAST, default 1, meaning special operands (exp 0 or 255) bypass iteration (1 = 1-cycle path, 0 = full latency).
REQ-003 The block SHALL have these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_a  in  32  IEEE-754 single operand A
- in_b  in  32  IEEE-754 single operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_p  out  32  product
- out_ovf  out  1  exponent overflow occurred
- out_unf  out  1  exponent underflow occurred
- busy  out  1  state != IDLE

Function
REQ-004 The block SHALL implement states IDLE, MUL, NORM and DONE, with in_ready = (state == IDLE) and busy = !in_ready.
REQ-005 On an edge with in_valid & in_ready, the block SHALL do all of the following:
- capture A and B;
- set sign = a[31]^b[31];
- set exp_sum (10-bit) = a[30:23] + b[30:23] - 127;
- set mant_a = {1,a[22:0]} and mant_b = {1,b[22:0]};
- clear the 48-bit accumulator and the 5-bit cnt;
- go to MUL.
REQ-006 Each MUL cycle SHALL do all of the following:
- if mant_b[cnt] = 1, add mant_a << cnt into the accumulator;
- increment cnt;
- after cnt = 23 is processed (24 MUL cycles), go to NORM.
REQ-007 The NORM cycle SHALL normalise and pack the result:
- if acc[47] = 1: mantissa = acc[46:24], exponent = exp_sum + 1;
- otherwise: mantissa = acc[45:23], exponent = exp_sum;
- truncation only, no rounding;
- then go to DONE.
REQ-008 The NORM cycle SHALL apply these range rules:
- final exponent >= 255 (signed): result = {sign, 8'hFF, 23'h0}, out_ovf = 1;
- final exponent <= 0 (signed): result = {sign, 31'h0}, out_unf = 1;
- otherwise result = {sign, exp[7:0], mantissa}.
REQ-009 The block SHALL treat operands with exponent 0 (zero/subnormal) as signed zero.
REQ-010 The block SHALL resolve special operands as follows:
- any NaN, or inf*zero: result = 32'h7FC00000;
- any inf otherwise: result = {sign, 8'hFF, 23'h0};
- any zero otherwise: result = {sign, 31'h0};
- no flags are set for special operands.
REQ-011 With SPECIAL_FAST = 1, a special operand pair SHALL go IDLE->DONE on the accepting edge; with SPECIAL_FAST = 0, it SHALL traverse MUL and NORM with the special result overriding at NORM.
REQ-012 Latency SHALL be counted from the accepting edge E0:
- normal operands: out_valid = 1 after edge E0+25;
- special operands with SPECIAL_FAST = 1: out_valid = 1 after E0+1.
REQ-013 In DONE, out_valid SHALL be 1, and out_p, out_ovf and out_unf SHALL be held stable until an edge with out_ready = 1.
REQ-014 On that out_ready edge, the block SHALL clear out_valid and return to IDLE; in_ready then rises, so the next accept happens no earlier than the following edge.
REQ-015 The block SHALL ignore in_valid whenever in_ready = 0, and in_a/in_b changes after capture SHALL have no effect.
REQ-016 Outside DONE, out_valid SHALL be 0 and out_p/out_ovf/out_unf SHALL hold their last values.

Reset
REQ-017 rst_n = 0 SHALL immediately force the following, regardless of clk:
- state = IDLE, out_valid = 0, out_p = 0, out_ovf = 0, out_unf = 0, cnt = 0, accumulator = 0;
- in_ready = 1, busy = 0.
REQ-018 Reset asserted mid-operation SHALL abort the operation, produce no result, and leave the block accepting new operands on the first edge after rst_n releases.

Verification
REQ-019 Bench case, basic multiply: a = 0x3FC00000 (1.5), b = 0x40000000 (2.0) -> out_p = 0x40400000, flags 0, out_valid exactly 25 edges after accept.
REQ-020 Bench case, normalise branch: a = 0x3FC00000, b = 0x3FC00000 -> out_p = 0x40100000 (2.25), acc[47] = 1 path.
REQ-021 Bench case, overflow: a = 0x7F000000, b = 0x7F000000 -> out_p = 0x7F800000, out_ovf = 1; a = 0x00800000, b = 0x00800000 -> out_p = 0x00000000, out_unf = 1.
REQ-022 Bench case, specials with SPECIAL_FAST = 1:
- 0x80000000 * 0x40490FDB -> 0x80000000, 1 cycle;
- 0x7F800000 * 0x00000000 -> 0x7FC00000;
- 0xFF800000 * 0x40000000 -> 0xFF800000.
REQ-023 Bench case, backpressure: hold out_ready = 0 for 10 cycles in DONE -> out_p stable, in_ready = 0; a new in_valid is not accepted until the edge after out_ready = 1.
REQ-024 Bench case, reset mid-op: assert rst_n = 0 at cnt = 12 -> all outputs 0 and in_ready = 1 asynchronously; a following 1.5*2.0 still yields 0x40400000.
